// File: rtl/gesture_pkg.sv
// Shared definitions for the gesture front end.
// Holds the default coordinate width, finger slot indices (thumb side = 0)
// and the state encoding of the finger status tracker.
package gesture_pkg;

    localparam int unsigned COORD_W_DEF = 8;

    localparam int unsigned THUMB  = 0;
    localparam int unsigned INDEX  = 1;
    localparam int unsigned MIDDLE = 2;
    localparam int unsigned RING   = 3;
    localparam int unsigned PINKY  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } tracker_state_t;

endpackage

// File: rtl/finger_debounce.sv
// One debounced finger flag.
// A per-frame raw flag must disagree with the held status for STABLE_FRAMES
// consecutive enabled frames before the status flips.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   en             one-cycle frame commit strobe
//   raw            raw flag for the frame being committed
//   status         registered debounced flag
//   status_next_c  value status takes at the next edge (combinational)
module finger_debounce #(
    parameter int unsigned STABLE_FRAMES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic raw,
    output logic status,
    output logic status_next_c
);

    localparam int unsigned CNT_W = $clog2(STABLE_FRAMES + 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // Agree counter: advances on disagreement, flips the flag on the last one.
    always_comb begin
        cnt_next      = cnt;
        status_next_c = status;
        if (en) begin
            if (raw != status) begin
                if (cnt == CNT_W'(STABLE_FRAMES - 1)) begin
                    status_next_c = raw;
                    cnt_next      = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end else begin
                cnt_next = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            status <= 1'b0;
        end else begin
            cnt    <= cnt_next;
            status <= status_next_c;
        end
    end

endmodule

// File: rtl/finger_status_tracker.sv
// Finger status tracker.
// Scans a band of image rows just above the palm box, splits the palm width
// into N_FINGERS bins, flags a bin when a foreground run of MIN_RUN pixels is
// seen, and debounces the per-bin flags across frames.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   frame_start, frame_end        frame delimiting pulses
//   pix_valid, pix, pix_r, pix_c  raster pixel stream
//   palm_valid, *_of_palm_*       palm box, sampled on frame_start
//   finger_status, finger_count   debounced flags and their population count
//   status_valid                  one-cycle pulse on every committed frame
module finger_status_tracker
    import gesture_pkg::*;
#(
    parameter int unsigned COORD_W       = COORD_W_DEF,
    parameter int unsigned N_FINGERS     = 5,
    parameter int unsigned SCAN_ROWS     = 4,
    parameter int unsigned MIN_RUN       = 2,
    parameter int unsigned STABLE_FRAMES = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             frame_start,
    input  logic                             frame_end,
    input  logic                             pix_valid,
    input  logic                             pix,
    input  logic [COORD_W-1:0]               pix_r,
    input  logic [COORD_W-1:0]               pix_c,
    input  logic                             palm_valid,
    input  logic [COORD_W-1:0]               start_of_palm_r,
    input  logic [COORD_W-1:0]               start_of_palm_c,
    input  logic [COORD_W-1:0]               end_of_palm_r,
    input  logic [COORD_W-1:0]               end_of_palm_c,
    output logic [N_FINGERS-1:0]             finger_status,
    output logic [$clog2(N_FINGERS+1)-1:0]   finger_count,
    output logic                             status_valid
);

    localparam int unsigned CNT_W = $clog2(N_FINGERS + 1);
    localparam int unsigned BIN_W = (N_FINGERS > 1) ? $clog2(N_FINGERS) : 1;
    localparam int unsigned RUN_W = $clog2(MIN_RUN + 1);
    localparam int unsigned ACC_W = COORD_W + CNT_W + 1;

    tracker_state_t state;
    tracker_state_t state_next;

    logic [COORD_W-1:0]   band_lo;
    logic [COORD_W-1:0]   band_top;
    logic [COORD_W-1:0]   col_lo;
    logic [COORD_W-1:0]   col_hi;
    logic [ACC_W-1:0]     width;
    logic [N_FINGERS-1:0] raw;
    logic [RUN_W-1:0]     run;
    logic [ACC_W-1:0]     acc;
    logic [BIN_W-1:0]     bin;

    logic                 box_ok_c;
    logic                 start_scan_c;
    logic                 in_band_c;
    logic                 row_start_c;
    logic [BIN_W-1:0]     cur_bin_c;
    logic [ACC_W-1:0]     cur_acc_c;
    logic [RUN_W-1:0]     cur_run_c;
    logic [ACC_W-1:0]     acc_sum_c;
    logic                 wrap_c;
    logic                 bin_step_c;
    logic [RUN_W-1:0]     run_pix_c;
    logic [ACC_W-1:0]     acc_next_c;
    logic [BIN_W-1:0]     bin_next_c;
    logic [RUN_W-1:0]     run_next_c;
    logic [N_FINGERS-1:0] raw_next_c;
    logic [N_FINGERS-1:0] status_next_c;
    logic [CNT_W-1:0]     count_next_c;
    logic [COORD_W-1:0]   band_lo_c;
    logic                 box_unused_c;

    // The band sits above the palm top, so the bottom edge of the box is not needed.
    assign box_unused_c = ^end_of_palm_r;

    assign box_ok_c = palm_valid && (end_of_palm_c >= start_of_palm_c);

    // A new frame is accepted from IDLE, or restarts SCAN when no frame_end coincides.
    assign start_scan_c = frame_start && box_ok_c &&
                          ((state == IDLE) || ((state == SCAN) && !frame_end));

    assign band_lo_c = (start_of_palm_r > COORD_W'(SCAN_ROWS)) ?
                       (start_of_palm_r - COORD_W'(SCAN_ROWS)) : '0;

    // Pixels arriving in a frame_start cycle belong to no latched box and are ignored.
    assign in_band_c = (state == SCAN) && !frame_start && pix_valid &&
                       (pix_r >= band_lo) && (pix_r < band_top) &&
                       (pix_c >= col_lo) && (pix_c <= col_hi);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (frame_start && box_ok_c) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (frame_end) begin
                    state_next = COMMIT;
                end else if (frame_start && !box_ok_c) begin
                    state_next = IDLE;
                end
            end
            COMMIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Divider-free binning: acc accumulates N_FINGERS per pixel and wraps at the width.
    always_comb begin
        row_start_c = (pix_c == col_lo);
        cur_bin_c   = row_start_c ? '0 : bin;
        cur_acc_c   = row_start_c ? '0 : acc;
        cur_run_c   = row_start_c ? '0 : run;
        acc_sum_c   = cur_acc_c + ACC_W'(N_FINGERS);
        wrap_c      = (acc_sum_c >= width);
        acc_next_c  = wrap_c ? (acc_sum_c - width) : acc_sum_c;
        bin_step_c  = wrap_c && (cur_bin_c != BIN_W'(N_FINGERS - 1));
        bin_next_c  = bin_step_c ? (cur_bin_c + 1'b1) : cur_bin_c;

        run_pix_c = '0;
        if (pix) begin
            run_pix_c = (cur_run_c == RUN_W'(MIN_RUN)) ? cur_run_c : (cur_run_c + 1'b1);
        end
        // A run never spans two bins.
        run_next_c = bin_step_c ? '0 : run_pix_c;

        raw_next_c = raw;
        for (int i = 0; i < int'(N_FINGERS); i++) begin
            if ((run_pix_c == RUN_W'(MIN_RUN)) && (cur_bin_c == BIN_W'(i))) begin
                raw_next_c[i] = 1'b1;
            end
        end
    end

    // Population count of the flags being registered this cycle.
    always_comb begin
        count_next_c = '0;
        for (int i = 0; i < int'(N_FINGERS); i++) begin
            count_next_c = count_next_c + CNT_W'(status_next_c[i]);
        end
    end

    // Box latch, scan datapath and output strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            band_lo      <= '0;
            band_top     <= '0;
            col_lo       <= '0;
            col_hi       <= '0;
            width        <= '0;
            raw          <= '0;
            run          <= '0;
            acc          <= '0;
            bin          <= '0;
            status_valid <= 1'b0;
            finger_count <= '0;
        end else begin
            status_valid <= (state == COMMIT);
            finger_count <= count_next_c;
            if (start_scan_c) begin
                band_lo  <= band_lo_c;
                band_top <= start_of_palm_r;
                col_lo   <= start_of_palm_c;
                col_hi   <= end_of_palm_c;
                width    <= ACC_W'(end_of_palm_c) - ACC_W'(start_of_palm_c) + ACC_W'(1);
                raw      <= '0;
                run      <= '0;
                acc      <= '0;
                bin      <= '0;
            end else if (in_band_c) begin
                raw <= raw_next_c;
                run <= run_next_c;
                acc <= acc_next_c;
                bin <= bin_next_c;
            end
        end
    end

    // One debouncer per finger slot, all committed together.
    for (genvar g = 0; g < int'(N_FINGERS); g++) begin : g_deb
        finger_debounce #(
            .STABLE_FRAMES (STABLE_FRAMES)
        ) u_deb (
            .clk           (clk),
            .rst           (rst),
            .en            (state == COMMIT),
            .raw           (raw[g]),
            .status        (finger_status[g]),
            .status_next_c (status_next_c[g])
        );
    end

endmodule

// File: tb/tb_finger_status_tracker.sv
// Directed bench for finger_status_tracker with an expected-result queue.
module tb_finger_status_tracker;

    localparam int unsigned CW = 8;
    localparam int unsigned NF = 5;
    localparam int IMG_R = 12;
    localparam int C_LO  = 16;
    localparam int C_HI  = 43;

    typedef struct packed {
        logic [NF-1:0] status;
        logic [2:0]    count;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_start;
    logic          frame_end;
    logic          pix_valid;
    logic          pix;
    logic [CW-1:0] pix_r;
    logic [CW-1:0] pix_c;
    logic          palm_valid;
    logic [CW-1:0] start_of_palm_r;
    logic [CW-1:0] start_of_palm_c;
    logic [CW-1:0] end_of_palm_r;
    logic [CW-1:0] end_of_palm_c;
    logic [NF-1:0] finger_status;
    logic [2:0]    finger_count;
    logic          status_valid;

    exp_t          sb_q[$];
    int            total = 0;
    int            bad = 0;
    int            pulses = 0;
    int            p0;
    logic          img [0:IMG_R-1][C_LO:C_HI];
    logic [NF-1:0] m_status;
    int            m_cnt [NF];

    always #5 clk = ~clk;

    finger_status_tracker #(
        .COORD_W       (CW),
        .N_FINGERS     (NF),
        .SCAN_ROWS     (4),
        .MIN_RUN       (2),
        .STABLE_FRAMES (3)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .frame_start     (frame_start),
        .frame_end       (frame_end),
        .pix_valid       (pix_valid),
        .pix             (pix),
        .pix_r           (pix_r),
        .pix_c           (pix_c),
        .palm_valid      (palm_valid),
        .start_of_palm_r (start_of_palm_r),
        .start_of_palm_c (start_of_palm_c),
        .end_of_palm_r   (end_of_palm_r),
        .end_of_palm_c   (end_of_palm_c),
        .finger_status   (finger_status),
        .finger_count    (finger_count),
        .status_valid    (status_valid)
    );

    always @(negedge clk) begin
        if (status_valid === 1'b1) pulses <= pulses + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_img();
        for (int r = 0; r < IMG_R; r++)
            for (int c = C_LO; c <= C_HI; c++)
                img[r][c] = 1'b0;
    endtask

    task automatic set_run(input int r, input int c, input int len);
        for (int k = 0; k < len; k++) img[r][c+k] = 1'b1;
    endtask

    task automatic model_reset();
        m_status = '0;
        for (int i = 0; i < NF; i++) m_cnt[i] = 0;
    endtask

    // Reference debounce, then push the expected outputs of this commit.
    task automatic model_commit(input logic [NF-1:0] raw);
        exp_t e;
        for (int i = 0; i < NF; i++) begin
            if (raw[i] != m_status[i]) begin
                m_cnt[i]++;
                if (m_cnt[i] == 3) begin
                    m_status[i] = raw[i];
                    m_cnt[i] = 0;
                end
            end else begin
                m_cnt[i] = 0;
            end
        end
        e.status = m_status;
        e.count  = 3'($countones(m_status));
        sb_q.push_back(e);
    endtask

    task automatic start_frame(input logic pv, input int sr, input int sc, input int ec);
        frame_start     = 1'b1;
        palm_valid      = pv;
        start_of_palm_r = CW'(sr);
        start_of_palm_c = CW'(sc);
        end_of_palm_r   = CW'(sr + 6);
        end_of_palm_c   = CW'(ec);
        tick();
        frame_start     = 1'b0;
        palm_valid      = 1'b0;
        start_of_palm_r = '0;
        start_of_palm_c = '0;
        end_of_palm_r   = '0;
        end_of_palm_c   = '0;
    endtask

    // Raster the image; occasional invalid cycles carry pix=1 and must be ignored.
    task automatic stream_pixels(input int max_pix);
        int n;
        n = 0;
        for (int r = 0; r < IMG_R; r++) begin
            for (int c = C_LO; c <= C_HI; c++) begin
                if (n < max_pix) begin
                    pix_valid = 1'b1;
                    pix       = img[r][c];
                    pix_r     = CW'(r);
                    pix_c     = CW'(c);
                    tick();
                    n++;
                    if ((c % 7) == 3) begin
                        pix_valid = 1'b0;
                        pix       = 1'b1;
                        tick();
                    end
                end
            end
        end
        pix_valid = 1'b0;
        pix       = 1'b0;
    endtask

    task automatic end_frame(input bit with_start);
        frame_end   = 1'b1;
        frame_start = with_start;
        if (with_start) begin
            palm_valid      = 1'b1;
            start_of_palm_r = CW'(10);
            start_of_palm_c = CW'(20);
            end_of_palm_r   = CW'(16);
            end_of_palm_c   = CW'(39);
        end
        tick();
        frame_end       = 1'b0;
        frame_start     = 1'b0;
        palm_valid      = 1'b0;
        start_of_palm_r = '0;
        start_of_palm_c = '0;
        end_of_palm_r   = '0;
        end_of_palm_c   = '0;
    endtask

    // Called one cycle after frame_end; the result must appear one cycle later.
    task automatic expect_commit(input string tag);
        exp_t e;
        check({tag, "_early"}, 32'(status_valid), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(status_valid), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, "_status"}, 32'(finger_status), 32'(e.status));
            check({tag, "_count"}, 32'(finger_count), 32'(e.count));
        end
        tick();
        check({tag, "_pulse1"}, 32'(status_valid), 32'd0);
    endtask

    task automatic frame(input string tag, input logic pv, input int sr, input int sc,
                         input int ec, input logic [NF-1:0] raw_exp);
        start_frame(pv, sr, sc, ec);
        stream_pixels(100000);
        end_frame(1'b0);
        if (pv) begin
            model_commit(raw_exp);
            expect_commit(tag);
        end
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; frame_end = 1'b0; pix_valid = 1'b0; pix = 1'b0;
        pix_r = '0; pix_c = '0; palm_valid = 1'b0; start_of_palm_r = '0;
        start_of_palm_c = '0; end_of_palm_r = '0; end_of_palm_c = '0;
        model_reset();
        clear_img();
        tick();
        tick();
        check("rst_status", 32'(finger_status), 32'd0);
        check("rst_count", 32'(finger_count), 32'd0);
        check("rst_valid", 32'(status_valid), 32'd0);
        rst = 1'b0;
        tick();

        // Five runs, one per 4-column bin, in the band above r=10.
        clear_img();
        for (int k = 0; k < 5; k++) set_run(8, 20 + 4*k, 2);
        frame("all_f1", 1'b1, 10, 20, 39, 5'b11111);
        frame("all_f2", 1'b1, 10, 20, 39, 5'b11111);
        frame("all_f3", 1'b1, 10, 20, 39, 5'b11111);

        // Thumb and pinky only, then empty frames.
        clear_img();
        set_run(7, 20, 2);
        set_run(7, 36, 2);
        for (int k = 0; k < 3; k++) frame("tp", 1'b1, 10, 20, 39, 5'b10001);
        clear_img();
        for (int k = 0; k < 3; k++) frame("empty", 1'b1, 10, 20, 39, 5'b00000);

        // Isolated pixels, a pair split by a bin boundary, a run outside the band.
        clear_img();
        img[9][20] = 1'b1; img[9][26] = 1'b1; img[9][30] = 1'b1;
        img[9][34] = 1'b1; img[9][38] = 1'b1;
        img[8][23] = 1'b1; img[8][24] = 1'b1;
        set_run(5, 28, 3);
        for (int k = 0; k < 3; k++) frame("iso", 1'b1, 10, 20, 39, 5'b00000);

        // Palm top at row 2: band is rows 0..1, palm row itself ignored.
        clear_img();
        set_run(0, 20, 2);
        set_run(1, 20, 2);
        set_run(2, 28, 3);
        for (int k = 0; k < 3; k++) frame("top2", 1'b1, 2, 20, 39, 5'b00001);

        // Palm top at row 0: empty band.
        clear_img();
        for (int k = 0; k < 5; k++) set_run(0, 20 + 4*k, 3);
        frame("band0", 1'b1, 0, 20, 39, 5'b00000);

        // Two stable frames, then reset mid-scan.
        clear_img();
        for (int k = 0; k < 5; k++) set_run(8, 20 + 4*k, 2);
        frame("pre_rst1", 1'b1, 10, 20, 39, 5'b11111);
        frame("pre_rst2", 1'b1, 10, 20, 39, 5'b11111);
        start_frame(1'b1, 10, 20, 39);
        stream_pixels(150);
        rst = 1'b1;
        tick();
        check("mrst_status", 32'(finger_status), 32'd0);
        check("mrst_count", 32'(finger_count), 32'd0);
        check("mrst_valid", 32'(status_valid), 32'd0);
        rst = 1'b0;
        model_reset();
        tick();
        frame("post_rst1", 1'b1, 10, 20, 39, 5'b11111);
        frame("post_rst2", 1'b1, 10, 20, 39, 5'b11111);
        frame("post_rst3", 1'b1, 10, 20, 39, 5'b11111);

        // Abandoned frames, then frame_end coinciding with frame_start.
        clear_img();
        p0 = pulses;
        start_frame(1'b1, 10, 20, 39);
        stream_pixels(100000);
        start_frame(1'b1, 10, 20, 39);
        stream_pixels(100000);
        tick();
        tick();
        check("abandon_pulses", 32'(pulses), 32'(p0));
        start_frame(1'b1, 10, 20, 39);
        stream_pixels(100000);
        end_frame(1'b1);
        model_commit(5'b00000);
        expect_commit("coinc");
        for (int k = 0; k < 4; k++) tick();
        check("coinc_pulses", 32'(pulses), 32'(p0 + 1));

        // Lone frame_end in IDLE, then a skipped frame.
        p0 = pulses;
        end_frame(1'b0);
        for (int k = 0; k < 4; k++) tick();
        check("idle_end_pulses", 32'(pulses), 32'(p0));
        start_frame(1'b0, 10, 20, 39);
        stream_pixels(100000);
        end_frame(1'b0);
        for (int k = 0; k < 4; k++) tick();
        check("skip_pulses", 32'(pulses), 32'(p0));

        // Only committed frames advance the debounce.
        frame("tail1", 1'b1, 10, 20, 39, 5'b00000);
        frame("tail2", 1'b1, 10, 20, 39, 5'b00000);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
